// File: rtl/acc_sched.sv
// acc_sched: round-robin scheduler that shares one accumulator add port among
// NUM_REQ requesters. Each grant lasts at most BURST beats. Every accepted beat
// becomes a registered one-cycle add strobe. Clear requests are serviced only
// between bursts.
// Optional feature: define ACC_SCHED_STATS_EN to build the saturating 16-bit
// beat_count statistic. Without it, beat_count is tied to zero.
module acc_sched #(
  parameter int NUM_REQ   = 4,
  parameter int ADD_WIDTH = 8,
  parameter int BURST     = 4,
  parameter int IDW       = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ADD_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           clr_req,
  output logic                           clr_ack,
  output logic [ADD_WIDTH-1:0]           acc_add_value,
  output logic                           acc_add_en,
  output logic                           acc_clr,
  output logic [IDW-1:0]                 grant_id,
  output logic                           busy,
  output logic [15:0]                    beat_count
);

  localparam int BCW = $clog2(BURST + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t                 state_r;
  logic [IDW-1:0]         ptr_r;
  logic [IDW-1:0]         owner_r;
  logic [BCW-1:0]         beat_cnt_r;
  logic [NUM_REQ-1:0]     ready_r;
  logic [ADD_WIDTH-1:0]   add_value_r;
  logic                   add_en_r;
  logic                   clr_r;
  logic                   ack_r;
  logic                   busy_r;

  logic [ADD_WIDTH-1:0]   lane_s [NUM_REQ];
  logic [IDW-1:0]         pick_s;
  logic                   found_s;
  logic [IDW:0]           sum_s;
  logic                   xfer_s;
  logic                   release_s;
  logic [IDW-1:0]         next_ptr_s;

  // Unpack the flat data bus into one lane per requester
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane_s[g] = req_data[g*ADD_WIDTH +: ADD_WIDTH];
  end

  // Round-robin search: first valid requester at or after ptr, wrapping
  always_comb begin
    pick_s  = ptr_r;
    found_s = 1'b0;
    sum_s   = {(IDW+1){1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s = {1'b0, ptr_r} + (IDW+1)'(k);
      if (sum_s >= (IDW+1)'(NUM_REQ)) begin
        sum_s = sum_s - (IDW+1)'(NUM_REQ);
      end else begin
        sum_s = sum_s;
      end
      if (!found_s && req_valid[sum_s[IDW-1:0]]) begin
        pick_s  = sum_s[IDW-1:0];
        found_s = 1'b1;
      end else begin
        pick_s  = pick_s;
      end
    end
  end

  // Transfer/release decode for the current owner and the rotated pointer
  always_comb begin
    xfer_s     = 1'b0;
    release_s  = 1'b0;
    next_ptr_s = owner_r + {{(IDW-1){1'b0}}, 1'b1};
    if (state_r == GRANT) begin
      xfer_s    = req_valid[owner_r] & ready_r[owner_r];
      // The last beat carries a transfer; a dropped valid releases with none
      release_s = ~req_valid[owner_r] | (beat_cnt_r == BCW'(BURST - 1));
    end else begin
      xfer_s    = 1'b0;
      release_s = 1'b0;
    end
    if (owner_r == IDW'(NUM_REQ - 1)) begin
      next_ptr_s = {IDW{1'b0}};
    end else begin
      next_ptr_s = owner_r + {{(IDW-1){1'b0}}, 1'b1};
    end
  end

  // Scheduler FSM with registered grant, strobe and clear outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      ptr_r       <= {IDW{1'b0}};
      owner_r     <= {IDW{1'b0}};
      beat_cnt_r  <= {BCW{1'b0}};
      ready_r     <= {NUM_REQ{1'b0}};
      add_value_r <= {ADD_WIDTH{1'b0}};
      add_en_r    <= 1'b0;
      clr_r       <= 1'b0;
      ack_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      add_en_r <= 1'b0;
      clr_r    <= 1'b0;
      ack_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (clr_req) begin
            state_r <= CLEAR;
            clr_r   <= 1'b1;
            ack_r   <= 1'b1;
            busy_r  <= 1'b1;
          end else if (|req_valid) begin
            state_r    <= GRANT;
            owner_r    <= pick_s;
            beat_cnt_r <= {BCW{1'b0}};
            ready_r    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
            busy_r     <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT: begin
          if (xfer_s) begin
            add_en_r    <= 1'b1;
            add_value_r <= lane_s[owner_r];
            beat_cnt_r  <= beat_cnt_r + {{(BCW-1){1'b0}}, 1'b1};
          end else begin
            beat_cnt_r  <= beat_cnt_r;
          end
          if (release_s) begin
            state_r <= IDLE;
            ptr_r   <= next_ptr_s;
            ready_r <= {NUM_REQ{1'b0}};
            busy_r  <= 1'b0;
          end else begin
            state_r <= GRANT;
          end
        end
        CLEAR: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          ready_r <= {NUM_REQ{1'b0}};
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready     = ready_r;
  assign acc_add_value = add_value_r;
  assign acc_add_en    = add_en_r;
  assign acc_clr       = clr_r;
  assign clr_ack       = ack_r;
  assign grant_id      = owner_r;
  assign busy          = busy_r;

`ifdef ACC_SCHED_STATS_EN
  logic [15:0] beat_count_r;

  // Saturating accepted-beat counter, zeroed on entry to CLEAR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_count_r <= 16'h0000;
    end else if (state_r == IDLE && clr_req) begin
      beat_count_r <= 16'h0000;
    end else if (xfer_s && beat_count_r != 16'hFFFF) begin
      beat_count_r <= beat_count_r + 16'h0001;
    end else begin
      beat_count_r <= beat_count_r;
    end
  end

  assign beat_count = beat_count_r;
`else
  assign beat_count = 16'h0000;
`endif

endmodule
